sync_fifo: RTL and testbench

//   Single-clock synchronous FIFO buffering DATA_W-bit words between a

---
 rtl/sync_fifo_if.sv | 24 ++
 rtl/sync_fifo.sv | 80 ++++++++
 tb/tb_sync_fifo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// The master modport is the side that drives requests; the slave modport is the FIFO.
interface sync_fifo_if #(
    parameter int unsigned DATA_W = 8
);
    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic [DATA_W-1:0] o_rddata;
    logic              o_empty;
    logic              o_alm_empty;
    logic              o_full;
    logic              o_alm_full;

    modport master (
        output i_wren, i_wrdata, i_rden,
        input  o_rddata, o_empty, o_alm_empty, o_full, o_alm_full
    );

    modport slave (
        input  i_wren, i_wrdata, i_rden,
        output o_rddata, o_empty, o_alm_empty, o_full, o_alm_full
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy counter and status flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through read data; default is 1-cycle registered read.
module sync_fifo #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ALM_FULL_LVL  = 14,
    parameter int unsigned ALM_EMPTY_LVL = 2
) (
    input  logic         clk,
    input  logic         rstn,
    sync_fifo_if.slave   bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic empty_c, full_c, wr_en_c, rd_en_c;

    // Flags come straight from the count register so both sides see the same view.
    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign wr_en_c = bus.i_wren && !full_c;
    assign rd_en_c = bus.i_rden && !empty_c;

    assign bus.o_empty     = empty_c;
    assign bus.o_full      = full_c;
    assign bus.o_alm_empty = (count_q <= CNT_W'(ALM_EMPTY_LVL));
    assign bus.o_alm_full  = (count_q >= CNT_W'(ALM_FULL_LVL));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_en_c) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (wr_en_c && !rd_en_c)      count_d = count_q + CNT_W'(1);
        else if (rd_en_c && !wr_en_c) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; contents are only observed after being written.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr_q] <= bus.i_wrdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.o_rddata = empty_c ? '0 : mem[rd_ptr_q];
`else
    logic [DATA_W-1:0] rddata_q, rddata_d;

    always_comb begin
        rddata_d = rddata_q;
        if (rd_en_c) rddata_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rddata_q <= '0;
        else       rddata_q <= rddata_d;
    end

    assign bus.o_rddata = rddata_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AF_LVL = 14;
    localparam int unsigned AE_LVL = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    sync_fifo_if #(.DATA_W(DATA_W)) bus ();

    sync_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH),
        .ALM_FULL_LVL(AF_LVL), .ALM_EMPTY_LVL(AE_LVL)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int unsigned cnt;
        logic [DATA_W-1:0] want_rd;
        cnt = q.size();
`ifdef SYNC_FIFO_FWFT_EN
        want_rd = (cnt == 0) ? '0 : q[0];
`else
        want_rd = exp_rd;
`endif
        check({tag, ".empty"},     32'(bus.o_empty),     32'(cnt == 0));
        check({tag, ".alm_empty"}, 32'(bus.o_alm_empty), 32'(cnt <= AE_LVL));
        check({tag, ".full"},      32'(bus.o_full),      32'(cnt == DEPTH));
        check({tag, ".alm_full"},  32'(bus.o_alm_full),  32'(cnt >= AF_LVL));
        check({tag, ".rddata"},    32'(bus.o_rddata),    32'(want_rd));
    endtask

    // One clock: drive requests, apply the rules to the model at the edge, compare after it.
    task automatic cycle(input logic we, input logic [DATA_W-1:0] wd, input logic re, input string tag);
        bit wr_ok, rd_ok;
        bus.i_wren   = we;
        bus.i_wrdata = wd;
        bus.i_rden   = re;
        @(posedge clk);
        wr_ok = we && (q.size() < DEPTH);
        rd_ok = re && (q.size() > 0);
        if (rd_ok) exp_rd = q.pop_front();
        if (wr_ok) q.push_back(wd);
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, '0, 1'b0, tag);
    endtask

    initial begin
        bus.i_wren   = 1'b0;
        bus.i_wrdata = '0;
        bus.i_rden   = 1'b0;

        #2;
        check_state("reset");
        @(negedge clk);
        rstn = 1'b1;
        idle("post_reset");

        // Mid-stream async reset with 5 words stored
        for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(8'h60 + i), 1'b0, "pre_rst_wr");
        cycle(1'b0, '0, 1'b1, "pre_rst_rd");
        bus.i_wren = 1'b0;
        bus.i_rden = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        q.delete();
        exp_rd = '0;
        check_state("rst_mid");
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b0, '0, 1'b1, "rd_after_rst");

        // Fill, then overflow attempt
        for (int i = 1; i <= 16; i++) cycle(1'b1, DATA_W'(i), 1'b0, "fill");
        cycle(1'b1, 8'hAA, 1'b0, "overflow");

        // Drain, then underflow attempt
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, "drain");
        cycle(1'b0, '0, 1'b1, "underflow");
        check("drain_last", 32'(bus.o_rddata), 32'(8'h10));

        // Pointer wrap-around
        for (int i = 0; i < 10; i++) cycle(1'b1, DATA_W'(8'h40 + i), 1'b0, "wrap_w10");
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, "wrap_r10");
        for (int i = 0; i < 12; i++) cycle(1'b1, DATA_W'(8'h20 + i), 1'b0, "wrap_w12");
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, "wrap_r12");

        // Simultaneous requests at full, empty and mid-level
        for (int i = 0; i < 16; i++) cycle(1'b1, DATA_W'(8'h80 + i), 1'b0, "sim_fill");
        cycle(1'b1, 8'hEE, 1'b1, "sim_full");
        check("sim_full_cnt15", 32'(q.size()), 32'd15);
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, "sim_drain");
        cycle(1'b1, 8'h77, 1'b1, "sim_empty");
        check("sim_empty_cnt1", 32'(q.size()), 32'd1);
        for (int i = 0; i < 7; i++) cycle(1'b1, DATA_W'(8'h90 + i), 1'b0, "sim_mid_fill");
        for (int i = 0; i < 6; i++) cycle(1'b1, DATA_W'(8'hA0 + i), 1'b1, "sim_mid");
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, "sim_mid_drain");

        // Head word visibility (fall-through build shows it without a read)
        cycle(1'b1, 8'h55, 1'b0, "head_wr");
        idle("head_idle");
        cycle(1'b0, '0, 1'b1, "head_pop");
        idle("head_empty");

        // Randomized traffic with varying bias to reach both boundaries
        for (int ph = 0; ph < 3; ph++) begin
            int unsigned wp, rp;
            wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            rp = 100 - wp;
            for (int i = 0; i < 600; i++) begin
                cycle(($urandom_range(99) < wp), DATA_W'($urandom), ($urandom_range(99) < rp), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
